// File: rtl/ct_pool_unit_pkg.sv
// Shared types and constants for the convolution pooling unit.
// Build option: define CT_POOL_RELU_EN to clamp negative samples to zero.
package ct_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int N_RES_DEF  = 4;
    localparam int SUM_W_DEF  = DATA_W_DEF + 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PRESENT = 2'd2
    } state_e;

    // Width of a sum of four DATA_W samples without wrap.
    function automatic int sum_w(input int dw);
        return dw + 2;
    endfunction

endpackage

// File: rtl/ct_pool_unit_if.sv
// Frame/result bus between the convolution controller, pool unit and consumer.
// Build option CT_POOL_RELU_EN changes only how res_data is interpreted.
interface ct_pool_unit_if
    import ct_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);

    logic              start;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic              res_done;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_max;
    logic [DATA_W+1:0] out_sum;
    logic [DATA_W-1:0] out_avg;
    logic              err_overrun;
    logic              err_underrun;

    modport master (
        output start, res_valid, res_data, res_done, out_ready,
        input  out_valid, out_max, out_sum, out_avg,
        input  err_overrun, err_underrun
    );

    modport slave (
        input  start, res_valid, res_data, res_done, out_ready,
        output out_valid, out_max, out_sum, out_avg,
        output err_overrun, err_underrun
    );

endinterface

// File: rtl/ct_pool_unit_max4.sv
// Unsigned maximum of four samples, purely combinational.
// Unaffected by CT_POOL_RELU_EN; clamping happens before this stage.
module ct_max4 #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] max_o
);

    logic [W-1:0] ab;
    logic [W-1:0] cd;

    // Balanced two-level compare tree.
    always_comb begin
        ab    = (a_i >= b_i) ? a_i : b_i;
        cd    = (c_i >= d_i) ? c_i : d_i;
        max_o = (ab >= cd) ? ab : cd;
    end

endmodule

// File: rtl/ct_pool_unit.sv
// 2x2 max/sum/average pooling of one convolution frame of N_RES samples.
// Define CT_POOL_RELU_EN to treat samples as signed and clamp negatives to 0.
module ct_pool_unit
    import ct_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int N_RES  = N_RES_DEF
) (
    input  logic           clk,
    input  logic           reset,
    ct_pool_unit_if.slave  pool_if
);

    localparam int       SW   = sum_w(DATA_W);
    localparam logic [1:0] LAST = 2'(N_RES - 1);

    state_e            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [DATA_W-1:0] samp_q [N_RES];
    logic [DATA_W-1:0] samp_d [N_RES];
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] max_q, max_d;
    logic [SW-1:0]     sum_q, sum_d;
    logic [DATA_W-1:0] avg_q, avg_d;
    logic              ovr_q, ovr_d;
    logic              unr_q, unr_d;

    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] max_new;
    logic [SW-1:0]     sum_new;

    // Sample conditioning ahead of storage and arithmetic.
    always_comb begin
`ifdef CT_POOL_RELU_EN
        din = pool_if.res_data[DATA_W-1] ? '0 : pool_if.res_data;
`else
        din = pool_if.res_data;
`endif
    end

    // Frame result uses the three stored samples plus the one arriving now.
    ct_max4 #(.W(DATA_W)) u_max4 (
        .a_i   (samp_q[0]),
        .b_i   (samp_q[1]),
        .c_i   (samp_q[2]),
        .d_i   (din),
        .max_o (max_new)
    );

    // Full-width sum so four max-value samples never wrap.
    always_comb begin
        sum_new = SW'(samp_q[0]) + SW'(samp_q[1])
                + SW'(samp_q[2]) + SW'(din);
    end

    // Next-state and datapath updates; start overrides everything.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        samp_d      = samp_q;
        out_valid_d = out_valid_q;
        max_d       = max_q;
        sum_d       = sum_q;
        avg_d       = avg_q;
        ovr_d       = ovr_q;
        unr_d       = unr_q;

        if (pool_if.start) begin
            state_d     = ST_COLLECT;
            idx_d       = '0;
            out_valid_d = 1'b0;
            ovr_d       = 1'b0;
            unr_d       = 1'b0;
            for (int i = 0; i < N_RES; i++) begin
                samp_d[i] = '0;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (pool_if.res_valid) begin
                        ovr_d = 1'b1;
                    end
                end
                ST_COLLECT: begin
                    if (pool_if.res_valid && idx_q == LAST) begin
                        samp_d[idx_q] = din;
                        idx_d         = '0;
                        max_d         = max_new;
                        sum_d         = sum_new;
                        avg_d         = sum_new[SW-1:2];
                        out_valid_d   = 1'b1;
                        state_d       = ST_PRESENT;
                    end else if (pool_if.res_done) begin
                        unr_d   = 1'b1;
                        idx_d   = '0;
                        state_d = ST_IDLE;
                    end else if (pool_if.res_valid) begin
                        samp_d[idx_q] = din;
                        idx_d         = idx_q + 2'd1;
                    end
                end
                ST_PRESENT: begin
                    if (pool_if.res_valid) begin
                        ovr_d = 1'b1;
                    end
                    if (out_valid_q && pool_if.out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = ST_IDLE;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    idx_d       = '0;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            max_q       <= '0;
            sum_q       <= '0;
            avg_q       <= '0;
            ovr_q       <= 1'b0;
            unr_q       <= 1'b0;
            for (int i = 0; i < N_RES; i++) begin
                samp_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            max_q       <= max_d;
            sum_q       <= sum_d;
            avg_q       <= avg_d;
            ovr_q       <= ovr_d;
            unr_q       <= unr_d;
            for (int i = 0; i < N_RES; i++) begin
                samp_q[i] <= samp_d[i];
            end
        end
    end

    assign pool_if.out_valid    = out_valid_q;
    assign pool_if.out_max      = max_q;
    assign pool_if.out_sum      = sum_q;
    assign pool_if.out_avg      = avg_q;
    assign pool_if.err_overrun  = ovr_q;
    assign pool_if.err_underrun = unr_q;

endmodule

// File: tb/tb_ct_pool_unit.sv
// Directed and randomized frames against a pooling reference model.
// Build with CT_POOL_RELU_EN to check the clamping variant.
module tb_ct_pool_unit;

    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    ct_pool_unit_if #(.DATA_W(DW)) bus ();

    ct_pool_unit #(.DATA_W(DW), .N_RES(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .pool_if (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic int relu(input int x);
`ifdef CT_POOL_RELU_EN
        return (x >= 128) ? 0 : x;
`else
        return x;
`endif
    endfunction

    // Reference: pooled max and sum of a frame, from the pooling rules.
    task automatic model(input int s[4], output int mx, output int sm);
        mx = 0;
        sm = 0;
        foreach (s[i]) begin
            int v;
            v = relu(s[i]);
            if (v > mx) mx = v;
            sm += v;
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    task automatic send(input int d);
        bus.res_valid = 1'b1;
        bus.res_data  = DW'(d);
        cyc();
        bus.res_valid = 1'b0;
    endtask

    task automatic run_frame(input string tag, input int s[4],
                             input int emax, input int esum,
                             input int stall, input bit gaps);
        bus.out_ready = (stall == 0);
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    cyc();
                    chk({tag, " gap_valid"}, 32'(bus.out_valid), 0);
                end
            end
            send(s[i]);
            if (i < 3) chk({tag, " early_valid"}, 32'(bus.out_valid), 0);
        end
        chk({tag, " valid"}, 32'(bus.out_valid), 1);
        chk({tag, " max"}, 32'(bus.out_max), emax);
        chk({tag, " sum"}, 32'(bus.out_sum), esum);
        chk({tag, " avg"}, 32'(bus.out_avg), esum >> 2);
        for (int j = 0; j < stall; j++) begin
            bus.res_done = (j == 0);
            cyc();
            bus.res_done = 1'b0;
            chk({tag, " hold_valid"}, 32'(bus.out_valid), 1);
            chk({tag, " hold_max"}, 32'(bus.out_max), emax);
            chk({tag, " hold_sum"}, 32'(bus.out_sum), esum);
        end
        bus.out_ready = 1'b1;
        cyc();
        chk({tag, " drop_valid"}, 32'(bus.out_valid), 0);
        chk({tag, " keep_max"}, 32'(bus.out_max), emax);
        chk({tag, " keep_avg"}, 32'(bus.out_avg), esum >> 2);
        chk({tag, " no_ovr"}, 32'(bus.err_overrun), 0);
        chk({tag, " no_unr"}, 32'(bus.err_underrun), 0);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int mx, sm;
        int s[4];

        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.res_valid = 1'b0;
        bus.res_data  = '0;
        bus.res_done  = 1'b0;
        bus.out_ready = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
        cyc();
        chk("rst valid", 32'(bus.out_valid), 0);
        chk("rst max", 32'(bus.out_max), 0);
        chk("rst sum", 32'(bus.out_sum), 0);
        chk("rst avg", 32'(bus.out_avg), 0);
        chk("rst ovr", 32'(bus.err_overrun), 0);
        chk("rst unr", 32'(bus.err_underrun), 0);

        run_frame("basic", '{10, 40, 20, 30}, 40, 100, 0, 0);

        s = '{255, 255, 255, 255};
        model(s, mx, sm);
        run_frame("full", s, mx, sm, 5, 0);

`ifdef CT_POOL_RELU_EN
        run_frame("relu", '{240, 5, 128, 3}, 5, 8, 1, 0);
`else
        run_frame("relu", '{240, 5, 128, 3}, 240, 376, 1, 0);
`endif

        pulse_start();
        send(1);
        send(2);
        bus.res_done = 1'b1;
        cyc();
        bus.res_done = 1'b0;
        chk("under flag", 32'(bus.err_underrun), 1);
        chk("under valid", 32'(bus.out_valid), 0);
        repeat (3) begin
            cyc();
            chk("under idle_valid", 32'(bus.out_valid), 0);
        end
        send(9);
        chk("under idle_ovr", 32'(bus.err_overrun), 1);
        pulse_start();
        chk("under clr", 32'(bus.err_underrun), 0);
        chk("under clr_ovr", 32'(bus.err_overrun), 0);

        reset = 1'b1;
        cyc();
        reset = 1'b0;
        send(7);
        chk("over flag", 32'(bus.err_overrun), 1);
        bus.start     = 1'b1;
        bus.res_valid = 1'b1;
        bus.res_data  = 8'd99;
        cyc();
        bus.start     = 1'b0;
        bus.res_valid = 1'b0;
        chk("over clr", 32'(bus.err_overrun), 0);
        send(1);
        send(2);
        send(3);
        chk("over idx0", 32'(bus.out_valid), 0);
        send(4);
        chk("over valid", 32'(bus.out_valid), 1);
        chk("over max", 32'(bus.out_max), 4);
        chk("over sum", 32'(bus.out_sum), 10);
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;

        pulse_start();
        send(200);
        send(200);
        send(200);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("abort valid", 32'(bus.out_valid), 0);
        chk("abort sum", 32'(bus.out_sum), 0);
        run_frame("abort", '{4, 4, 4, 4}, 4, 16, 0, 0);

        for (int f = 0; f < 20; f++) begin
            foreach (s[i]) s[i] = $urandom_range(0, 255);
            model(s, mx, sm);
            run_frame("rand", s, mx, sm, $urandom_range(0, 3), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ct_pool_unit.md
CT_POOL_UNIT -- requirements
Module: ct_pool_unit

Interface
REQ-001 Parameter DATA_W, default 8: width of each convolution result sample.
REQ-002 Parameter N_RES, default 4: results per frame (2x2 output map).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  single-cycle pulse; begins a new frame, driven with the convolution controller's enable.
REQ-006 res_valid  input  1  result sample valid strobe from the convolution controller.
REQ-007 res_data  input  DATA_W  result sample, sampled only when res_valid=1.
REQ-008 res_done  input  1  end-of-frame strobe from the convolution controller.
REQ-009 out_valid  output  1  pooled frame available.
REQ-010 out_ready  input  1  consumer accepts pooled frame.
REQ-011 out_max  output  DATA_W  maximum of the N_RES stored samples (2x2 max-pool).
REQ-012 out_sum  output  DATA_W+2  sum of the N_RES stored samples.
REQ-013 out_avg  output  DATA_W  out_sum >> 2, truncated.
REQ-014 err_overrun  output  1  sticky: sample arrived outside COLLECT.
REQ-015 err_underrun  output  1  sticky: res_done arrived before N_RES samples.

Function
REQ-016 FSM states IDLE, COLLECT, PRESENT; 2-bit sample index idx.
REQ-017 start in any state -> COLLECT, idx=0, out_valid=0, sample registers cleared; start has priority over every other input in that cycle.
REQ-018 COLLECT: each res_valid=1 stores res_data into slot idx and increments idx.
REQ-019 On the capture of sample N_RES, out_max/out_sum/out_avg register from the three stored samples plus the incoming one on the same edge; state -> PRESENT; out_valid=1 the following cycle (latency 1 cycle from last res_valid).
REQ-020 PRESENT: out_valid and outputs held stable until out_valid && out_ready; then -> IDLE, out_valid=0 next cycle; out_max/out_sum/out_avg retain last values.
REQ-021 out_ready is ignored when out_valid=0.
REQ-022 res_valid in IDLE or PRESENT: sample discarded, err_overrun set.
REQ-023 res_done in COLLECT with fewer than N_RES samples captured: err_underrun set, -> IDLE, no out_valid.
REQ-024 res_done in any other state or after the final sample: no effect.
REQ-025 Max comparison unsigned; out_sum computed at full DATA_W+2 width, never wraps.
REQ-026 err_overrun/err_underrun clear only on start or reset.

Reset
REQ-027 reset -> IDLE, idx=0, sample registers 0, out_valid=0, out_max=0, out_sum=0, out_avg=0, err_overrun=0, err_underrun=0.
REQ-028 reset has priority over start; reset mid-frame discards all captured samples.

Configuration
REQ-029 Macro CT_POOL_RELU_EN defined: res_data interpreted as signed two's complement; negative samples replaced by 0 before storage and before all max/sum arithmetic.
REQ-030 CT_POOL_RELU_EN undefined: res_data treated as unsigned and stored unchanged.

Structure
REQ-031 Shared package ct_pkg holds FSM state enumeration, DATA_W and N_RES defaults, and output-width constant DATA_W+2.
REQ-032 One combinational sub-module ct_max4 computes the unsigned 4-input maximum; all sequential logic stays in ct_pool_unit.

Verification
REQ-033 start; res_valid samples 10,40,20,30; out_ready=1 -> out_valid one cycle after 4th sample, out_max=40, out_sum=100, out_avg=25, out_valid low next cycle.
REQ-034 start; samples 255,255,255,255; out_ready=0 for 5 cycles -> out_valid held, out_max=255, out_sum=1020, out_avg=255, stable until out_ready=1.
REQ-035 RELU_EN build: samples 0xF0,5,0x80,3 -> out_max=5, out_sum=8, out_avg=2; non-RELU build same stimulus -> out_max=240, out_sum=376, out_avg=94.
REQ-036 start; samples 1,2; res_done -> err_underrun=1, state IDLE, out_valid never asserted; next start clears err_underrun.
REQ-037 res_valid with data 7 while IDLE -> err_overrun=1, no stored sample; start with simultaneous res_valid -> sample discarded, idx=0.
REQ-038 reset after 3 samples, then start and samples 4,4,4,4 -> out_max=4, out_sum=16, no residue from aborted frame.
